// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit
//   Iterative shift-add multiplier for mult/multu that also owns the HI/LO
//   registers. One multiplier bit is consumed per clock. The fetch stage is
//   stalled while the multiply is in flight so HI/LO are valid before any
//   mfhi/mflo can read them.
//
//   Ports
//     clk          clock, all state on the rising edge
//     rst          asynchronous active-low reset
//     enhilo_EX    start request (mult/multu decoded)
//     signed_EX    1 = mult (signed), 0 = multu
//     a_EX, b_EX   rs / rt operands, sampled only on the start edge
//     stall_FETCH  high while a multiply is in progress (state != IDLE)
//     done         one-cycle pulse after HI/LO have been written
//     hi, lo       HI / LO registers (upper / lower half of the product)
module hilo_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enhilo_EX,
  input  logic             signed_EX,
  input  logic [WIDTH-1:0] a_EX,
  input  logic [WIDTH-1:0] b_EX,
  output logic             stall_FETCH,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand, pre-shifted by count
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_s;

  // Magnitude of a two's complement operand; the most negative value maps
  // onto itself, which is the correct magnitude when read as unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      abs_val = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      abs_val = v;
    end
  endfunction

  // Two's complement negation over the full double-width product.
  function automatic logic [2*WIDTH-1:0] neg2w(input logic [2*WIDTH-1:0] v);
    neg2w = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Final sign correction applied on the FIX edge.
  always_comb begin
    if (neg_q) begin
      product_s = neg2w(acc_q);
    end else begin
      product_s = acc_q;
    end
  end

  // Next-state and datapath control for IDLE -> RUN -> FIX -> IDLE.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enhilo_EX) begin
          if (signed_EX) begin
            mcand_d  = {{WIDTH{1'b0}}, abs_val(a_EX)};
            mplier_d = abs_val(b_EX);
            neg_d    = a_EX[WIDTH-1] ^ b_EX[WIDTH-1];
          end else begin
            mcand_d  = {{WIDTH{1'b0}}, a_EX};
            mplier_d = b_EX;
            neg_d    = 1'b0;
          end
          acc_d   = {(2*WIDTH){1'b0}};
          count_d = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end else begin
          acc_d = acc_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + {{(CW-1){1'b0}}, 1'b1};
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end else begin
          state_d = RUN;
        end
      end
      FIX: begin
        hi_d    = product_s[2*WIDTH-1:WIDTH];
        lo_d    = product_s[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight multiply.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      count_q  <= {CW{1'b0}};
      neg_q    <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign stall_FETCH = (state_q != IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed testbench for hilo_mult_unit: table of multiply vectors plus
// hand-written sequences for back-to-back starts, ignored requests and
// reset during a multiply.
module tb_hilo_mult_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         enhilo_EX;
  logic         signed_EX;
  logic [W-1:0] a_EX;
  logic [W-1:0] b_EX;
  logic         stall_FETCH;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_hi;
  logic [W-1:0] last_lo;

  typedef struct {
    string      name;
    logic       sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[9];

  hilo_mult_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .enhilo_EX   (enhilo_EX),
    .signed_EX   (signed_EX),
    .a_EX        (a_EX),
    .b_EX        (b_EX),
    .stall_FETCH (stall_FETCH),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Starts an operation (caller is at a negedge), waits for done, checks the
  // stall length and result. inj_n >= 1 injects a 2x2 request at that
  // negedge after the start edge. Returns at the negedge where done is high.
  task automatic do_op(input string name, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi,
                       input logic [31:0] elo, input int inj_n);
    int  stall_cnt;
    bit  seen;
    signed_EX = sgn;
    a_EX      = a;
    b_EX      = b;
    enhilo_EX = 1'b1;
    @(posedge clk);
    #1;
    enhilo_EX = 1'b0;
    a_EX      = ~a;
    b_EX      = ~b;
    signed_EX = ~sgn;
    stall_cnt = 0;
    seen      = 1'b0;
    for (int n = 1; n <= 100 && !seen; n++) begin
      @(negedge clk);
      if (n == inj_n) begin
        enhilo_EX = 1'b1;
        a_EX      = 32'd2;
        b_EX      = 32'd2;
        signed_EX = 1'b0;
      end else if (n == inj_n + 1) begin
        enhilo_EX = 1'b0;
      end else begin
        enhilo_EX = enhilo_EX;
      end
      if (n == 1) chk({name, "_hold"}, {hi, lo}, {last_hi, last_lo});
      if (done) seen = 1'b1;
      else if (stall_FETCH) stall_cnt++;
    end
    chk({name, "_done_seen"}, {63'd0, seen}, 64'd1);
    chk({name, "_stall_cycles"}, 64'(stall_cnt), 64'(W + 1));
    chk({name, "_stall_at_done"}, {63'd0, stall_FETCH}, 64'd0);
    chk({name, "_hi"}, {32'd0, hi}, {32'd0, ehi});
    chk({name, "_lo"}, {32'd0, lo}, {32'd0, elo});
    last_hi = ehi;
    last_lo = elo;
  endtask

  initial begin
    int extra;

    vecs[0] = '{"multu_6x7",      1'b0, 32'd6,        32'd7,        32'h00000000, 32'h0000002A};
    vecs[1] = '{"mult_m3x5",      1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{"multu_max",      1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[3] = '{"mult_m1xm1",     1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[4] = '{"mult_minxmin",   1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[5] = '{"multu_zero",     1'b0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
    vecs[6] = '{"mult_7xm1",      1'b1, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[7] = '{"multu_min_x2",   1'b0, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000};
    vecs[8] = '{"mult_min_x1",    1'b1, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000};

    rst       = 1'b0;
    enhilo_EX = 1'b0;
    signed_EX = 1'b0;
    a_EX      = '0;
    b_EX      = '0;
    last_hi   = '0;
    last_lo   = '0;

    repeat (2) @(negedge clk);
    chk("reset_hilo",  {hi, lo}, 64'd0);
    chk("reset_stall", {63'd0, stall_FETCH}, 64'd0);
    chk("reset_done",  {63'd0, done}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, -1);
      @(negedge clk);
      chk({vecs[i].name, "_done_drop"}, {63'd0, done}, 64'd0);
    end

    // Back-to-back: second start issued in the cycle done is high.
    do_op("b2b_first",  1'b0, 32'd10,       32'd20, 32'h00000000, 32'd200,      -1);
    do_op("b2b_second", 1'b1, 32'hFFFFFFFC, 32'd6,  32'hFFFFFFFF, 32'hFFFFFFE8, -1);
    @(negedge clk);
    chk("b2b_done_drop", {63'd0, done}, 64'd0);

    // Request during RUN (count=5) must be ignored.
    do_op("ignore", 1'b0, 32'd3, 32'd4, 32'h00000000, 32'd12, 6);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (stall_FETCH) extra++;
      if (done && extra > 0) extra++;
    end
    chk("ignore_no_second_op", 64'(extra), 64'd0);
    chk("ignore_hilo_kept", {hi, lo}, {32'd0, 32'd12});

    // Reset in the middle of a multiply.
    do_op("load_42", 1'b0, 32'd6, 32'd7, 32'h00000000, 32'd42, -1);
    @(negedge clk);
    signed_EX = 1'b0;
    a_EX      = 32'd9;
    b_EX      = 32'd9;
    enhilo_EX = 1'b1;
    @(posedge clk);
    #1;
    enhilo_EX = 1'b0;
    repeat (11) @(negedge clk);
    chk("pre_reset_hilo_held", {hi, lo}, {32'd0, 32'd42});
    rst = 1'b0;
    #1;
    chk("midreset_hilo",  {hi, lo}, 64'd0);
    chk("midreset_stall", {63'd0, stall_FETCH}, 64'd0);
    chk("midreset_done",  {63'd0, done}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || stall_FETCH) extra++;
    end
    chk("postreset_quiet", 64'(extra), 64'd0);
    chk("postreset_hilo", {hi, lo}, 64'd0);
    last_hi = '0;
    last_lo = '0;
    do_op("after_reset", 1'b0, 32'd5, 32'd5, 32'h00000000, 32'd25, -1);
    @(negedge clk);
    chk("after_reset_done_drop", {63'd0, done}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
